// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store engine: turns load/store requests into word-bus transactions on a
// variable-latency data memory. Optional macro MISALIGN_TRAP_EN traps misaligned H/W accesses.
module data_mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  output logic [31:0] read_data,
  output logic        busywait,
  output logic        bus_error,
  output logic        dm_req,
  output logic        dm_we,
  output logic [29:0] dm_addr,
  output logic [3:0]  dm_byte_en,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

  state_e     state;
  logic [7:0] tmo_cnt;

  // Attributes of the in-flight access, needed to extract the load result on ACK.
  logic       op_load;
  logic       op_unsigned;
  size_e      op_size;
  logic [1:0] op_lane;

  logic        req;
  logic        misaligned;
  logic        trap;
  size_e       size;
  logic [1:0]  lane;
  logic [3:0]  byte_en;
  logic [31:0] wdata;

  // A simultaneous read+write is a store, so mem_write alone selects the decode table.
  always_comb begin
    req  = mem_read | mem_write;
    size = SzWord;
    if (mem_write) begin
      unique case (func3[1:0])
        2'b00:   size = SzByte;
        2'b01:   size = SzHalf;
        default: size = SzWord;
      endcase
    end else begin
      unique case (func3)
        3'b000, 3'b100: size = SzByte;
        3'b001, 3'b101: size = SzHalf;
        default:        size = SzWord;
      endcase
    end
  end

  always_comb begin
    lane    = 2'b00;
    byte_en = 4'b1111;
    wdata   = mem_write_data;
    unique case (size)
      SzByte: begin
        lane    = mem_address[1:0];
        byte_en = 4'b0001 << mem_address[1:0];
        wdata   = {4{mem_write_data[7:0]}};
      end
      SzHalf: begin
        lane    = {mem_address[1], 1'b0};
        byte_en = mem_address[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{mem_write_data[15:0]}};
      end
      default: begin
        lane    = 2'b00;
        byte_en = 4'b1111;
        wdata   = mem_write_data;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((size == SzHalf) && mem_address[0]) ||
                      ((size == SzWord) && (mem_address[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign trap = req & misaligned;

  // Combinational so the pipeline freezes in the same cycle the request appears.
  assign busywait = reset & ((state == StAccess) | ((state == StIdle) & req));

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    ld_byte = dm_rdata[{op_lane, 3'b000} +: 8];
    ld_half = op_lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    unique case (op_size)
      SzByte:  ld_ext = {{24{~op_unsigned & ld_byte[7]}}, ld_byte};
      SzHalf:  ld_ext = {{16{~op_unsigned & ld_half[15]}}, ld_half};
      default: ld_ext = dm_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= StIdle;
      tmo_cnt     <= 8'd0;
      read_data   <= 32'd0;
      bus_error   <= 1'b0;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= 30'd0;
      dm_byte_en  <= 4'd0;
      dm_wdata    <= 32'd0;
      op_load     <= 1'b0;
      op_unsigned <= 1'b0;
      op_size     <= SzWord;
      op_lane     <= 2'b00;
    end else begin
      bus_error <= 1'b0;
      unique case (state)
        StIdle: begin
          if (trap) begin
            read_data <= 32'd0;
            bus_error <= 1'b1;
            state     <= StDone;
          end else if (req) begin
            dm_req      <= 1'b1;
            dm_we       <= mem_write;
            dm_addr     <= mem_address[31:2];
            dm_byte_en  <= byte_en;
            dm_wdata    <= wdata;
            op_load     <= ~mem_write;
            op_unsigned <= func3[2];
            op_size     <= size;
            op_lane     <= lane;
            tmo_cnt     <= 8'd0;
            state       <= StAccess;
          end
        end
        StAccess: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            if (op_load) begin
              read_data <= ld_ext;
            end
            state <= StDone;
          end else if (tmo_cnt == TmoLast) begin
            dm_req    <= 1'b0;
            read_data <= 32'd0;
            bus_error <= 1'b1;
            state     <= StDone;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Self-checking bench for data_mem_access_unit: directed cases plus randomized loads/stores
// compared every cycle against a transaction-level model with a sparse word memory.
module tb_data_mem_access_unit;
  localparam int unsigned Tmo = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] read_data;
  logic        busywait;
  logic        bus_error;
  logic        dm_req;
  logic        dm_we;
  logic [29:0] dm_addr;
  logic [3:0]  dm_byte_en;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  always #5 clk = ~clk;

  data_mem_access_unit #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .func3          (func3),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .read_data      (read_data),
    .busywait       (busywait),
    .bus_error      (bus_error),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_byte_en     (dm_byte_en),
    .dm_wdata       (dm_wdata),
    .dm_rdata       (dm_rdata),
    .dm_ack         (dm_ack)
  );

  int checks;
  int passed;

  bit          chk_en;
  logic        exp_busy;
  logic        exp_req;
  logic        exp_err;
  logic        exp_we;
  logic        exp_store;
  logic [29:0] exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata;
  logic [31:0] model_rd;
  logic [31:0] mem [int];

  int          cap_busy;
  int          cap_req;
  logic        cap_err;
  logic        cap_we;
  logic [29:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic [31:0] cap_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busywait", 32'(busywait), 32'(exp_busy));
      check("dm_req", 32'(dm_req), 32'(exp_req));
      check("bus_error", 32'(bus_error), 32'(exp_err));
      check("read_data", read_data, model_rd);
      if (exp_req) begin
        check("dm_we", 32'(dm_we), 32'(exp_we));
        check("dm_addr", 32'(dm_addr), 32'(exp_addr));
        check("dm_byte_en", 32'(dm_byte_en), 32'(exp_be));
        if (exp_store) check("dm_wdata", dm_wdata, exp_wdata);
      end
    end
  end

  function automatic int op_bytes(input bit st, input logic [2:0] f3);
    if (st) return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input int n, input int ofs,
                                           input bit sgn);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (n == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * n)) - 1);
    v = (w >> (8 * ofs)) & mask;
    if (sgn && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic get_word(input int w, output logic [31:0] v);
    if (!mem.exists(w)) mem[w] = $urandom;
    v = mem[w];
  endtask

  // Samples at the falling edge, then returns just after the next rising edge.
  task automatic sample_cycle();
    @(negedge clk);
    if (busywait) cap_busy++;
    if (dm_req) begin
      if (cap_req == 0) begin
        cap_addr  = dm_addr;
        cap_be    = dm_byte_en;
        cap_we    = dm_we;
        cap_wdata = dm_wdata;
      end
      cap_req++;
    end
    if (bus_error) cap_err = 1'b1;
    cap_rd = read_data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input bit spur);
    exp_busy = 1'b0;
    exp_req  = 1'b0;
    exp_err  = 1'b0;
    dm_ack   = spur;
    dm_rdata = $urandom;
    sample_cycle();
    dm_ack = 1'b0;
  endtask

  // ack_at: ACCESS cycle (1-based) carrying DM_ACK; 0 means never acknowledge.
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at, input bit spur);
    bit          st;
    bit          trap;
    bit          acked;
    int          n;
    int          ofs;
    int          wkey;
    logic [31:0] word;
    logic [31:0] w;
    st    = wr;
    trap  = 1'b0;
    acked = 1'b0;
    n     = op_bytes(st, f3);
    ofs   = int'(a[1:0]);
`ifdef MISALIGN_TRAP_EN
    trap = (ofs % n) != 0;
`endif
    ofs  = ofs - (ofs % n);
    wkey = int'(a[31:2]);
    get_word(wkey, word);
    for (int i = 0; i < 4; i++) w[8 * i +: 8] = wd[8 * (i % n) +: 8];
    cap_busy = 0;
    cap_req  = 0;
    cap_err  = 1'b0;

    mem_read       = rd;
    mem_write      = wr;
    func3          = f3;
    mem_address    = a;
    mem_write_data = wd;
    exp_busy  = 1'b1;
    exp_req   = 1'b0;
    exp_err   = 1'b0;
    exp_store = st;
    exp_we    = st;
    exp_addr  = a[31:2];
    exp_be    = 4'(((1 << n) - 1) << ofs);
    exp_wdata = w;
    sample_cycle();

    if (!trap) begin
      exp_req = 1'b1;
      for (int j = 1; j <= int'(Tmo) && !acked; j++) begin
        if (j == ack_at) begin
          dm_ack   = 1'b1;
          dm_rdata = word;
          acked    = 1'b1;
        end else begin
          dm_rdata = $urandom;
        end
        sample_cycle();
        dm_ack = 1'b0;
      end
    end

    exp_busy = 1'b0;
    exp_req  = 1'b0;
    exp_err  = !acked;
    if (!acked) begin
      model_rd = 32'd0;
    end else if (!st) begin
      model_rd = load_val(word, n, ofs, !f3[2]);
    end else begin
      for (int i = 0; i < 4; i++) if (exp_be[i]) word[8 * i +: 8] = w[8 * i +: 8];
      mem[wkey] = word;
    end
    if (spur) begin
      dm_ack   = 1'b1;
      dm_rdata = $urandom;
    end
    sample_cycle();
    dm_ack    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    exp_err   = 1'b0;
    exp_busy  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          kind;
    int          ack_at;
    bit          rd;
    bit          wr;
    logic [31:0] a;
    checks = 0;
    passed = 0;
    chk_en = 1'b0;
    exp_busy = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_we = 1'b0; exp_store = 1'b0;
    exp_addr = '0; exp_be = '0; exp_wdata = '0; model_rd = '0;
    reset = 1'b0; mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010;
    mem_address = 32'h100; mem_write_data = 32'h0; dm_rdata = 32'h0; dm_ack = 1'b0;

    // Reset state, with a request already presented.
    repeat (2) @(posedge clk);
    #3;
    check("reset_busywait", 32'(busywait), 32'd0);
    check("reset_dm_req", 32'(dm_req), 32'd0);
    check("reset_bus_error", 32'(bus_error), 32'd0);
    check("reset_read_data", read_data, 32'd0);
    check("reset_dm_byte_en", 32'(dm_byte_en), 32'd0);
    check("reset_dm_addr", 32'(dm_addr), 32'd0);
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;

    mem[32'h40] = 32'hDEAD_BEEF;
    run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 1'b0);
    check("lw_addr", 32'(cap_addr), 32'h40);
    check("lw_be", 32'(cap_be), 32'hF);
    check("lw_busy_cycles", 32'(cap_busy), 32'd4);
    check("lw_read_data", cap_rd, 32'hDEAD_BEEF);

    mem[32'h40] = 32'h8011_2233;
    run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 1'b0);
    check("lb_be", 32'(cap_be), 32'h8);
    check("lb_read_data", cap_rd, 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 2, 1'b1);
    check("lbu_read_data", cap_rd, 32'h0000_0080);

    idle_cycle(1'b1);
    run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 2, 1'b0);
    check("sh_we", 32'(cap_we), 32'd1);
    check("sh_be", 32'(cap_be), 32'hC);
    check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    run_op(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 1, 1'b0);
    check("lhu_read_data", cap_rd, 32'h0000_ABCD);

    run_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 1'b0);
    check("timeout_req_cycles", 32'(cap_req), 32'd8);
    check("timeout_bus_error", 32'(cap_err), 32'd1);
    check("timeout_read_data", cap_rd, 32'd0);
    check("timeout_busy_cycles", 32'(cap_busy), 32'd9);

    run_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 2, 1'b0);
`ifdef MISALIGN_TRAP_EN
    check("misalign_req_cycles", 32'(cap_req), 32'd0);
    check("misalign_bus_error", 32'(cap_err), 32'd1);
    check("misalign_read_data", cap_rd, 32'd0);
`else
    check("misalign_addr", 32'(cap_addr), 32'h40);
    check("misalign_be", 32'(cap_be), 32'hF);
    check("misalign_read_data", cap_rd, 32'h8011_2233);
`endif

    // Reset asserted in the middle of an access, then a stray late ACK.
    chk_en      = 1'b0;
    mem_read    = 1'b1;
    func3       = 3'b010;
    mem_address = 32'h400;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_dm_req", 32'(dm_req), 32'd0);
    check("rst_mid_busywait", 32'(busywait), 32'd0);
    check("rst_mid_read_data", read_data, 32'd0);
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    dm_ack   = 1'b1;
    dm_rdata = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("late_ack_dm_req", 32'(dm_req), 32'd0);
    check("late_ack_busywait", 32'(busywait), 32'd0);
    @(posedge clk);
    #1;
    dm_ack = 1'b0;
    @(negedge clk);
    check("late_ack_bus_error", 32'(bus_error), 32'd0);
    check("late_ack_read_data", read_data, 32'd0);
    @(posedge clk);
    #1;
    model_rd = 32'd0;
    exp_busy = 1'b0;
    exp_req  = 1'b0;
    exp_err  = 1'b0;
    chk_en   = 1'b1;
    mem[32'h41] = 32'h1234_5678;
    run_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 2, 1'b0);
    check("post_rst_read_data", cap_rd, 32'h1234_5678);
    check("post_rst_busy_cycles", 32'(cap_busy), 32'd3);

    for (int k = 0; k < 300; k++) begin
      kind = $urandom_range(0, 9);
      rd   = (kind < 5) || (kind == 9);
      wr   = (kind >= 5);
      a    = 32'h1000 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom);
      if ($urandom_range(0, 19) == 0) ack_at = 0;
      else ack_at = $urandom_range(1, (k % 4 == 0) ? 8 : 4);
      run_op(rd, wr, 3'($urandom_range(0, 7)), a, $urandom, ack_at,
             $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) idle_cycle($urandom_range(0, 3) == 0);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
